// File: rtl/crc32_frame_check.sv
// ----------------------------------------------------------------------------
// crc32_frame_check
//
// Receive-side CRC-32 checker for 32-bit word streams. A frame is a run of
// payload words terminated by one trailer word (s_last=1) that carries the
// CRC-32 appended by the transmit-side generator. The checker recomputes the
// CRC over the payload and emits one result record per frame over a
// valid/ready handshake.
//
// CRC: polynomial 0x04C11DB7, 32 data bits per step (s_data[i] is data bit i),
// init 0xFFFFFFFF, no reflection, no final XOR. Next state = M*(lfsr ^ data).
//
// Optional build macro: CRC32_FRAME_CHECK_STATS_EN adds saturating good/bad
// frame counters (stat_ok, stat_err) with a clear input (stat_clr).
//
// Parameters:
//   CNT_W      width of the payload word counter and m_len
//   MAX_WORDS  largest legal payload length in words (must be < 2^CNT_W)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   s_valid    input word valid
//   s_ready    checker can accept a word (registered)
//   s_data     payload word, or CRC trailer when s_last=1
//   s_last     current word is the CRC trailer
//   m_valid    result valid
//   m_ready    result consumer ready
//   m_ok       CRC matched and frame not overlength
//   m_len      payload word count (trailer excluded)
//   m_overlen  payload exceeded MAX_WORDS
//   busy       frame in progress
//   stat_clr   (stats build) clear both counters
//   stat_ok    (stats build) count of good frames, saturating
//   stat_err   (stats build) count of bad frames, saturating
// ----------------------------------------------------------------------------
module crc32_frame_check #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_ok,
    output logic [CNT_W-1:0] m_len,
    output logic             m_overlen,
`ifdef CRC32_FRAME_CHECK_STATS_EN
    input  logic             stat_clr,
    output logic [31:0]      stat_ok,
    output logic [31:0]      stat_err,
`endif
    output logic             busy
);

    localparam logic [31:0]      POLY     = 32'h04C11DB7;
    localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StResult
    } state_e;

    // One 32-bit step: fold the word into the register, then clock the LFSR
    // 32 times. Equivalent to feeding data MSB-first through a serial LFSR.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] x;
        x = crc ^ data;
        for (int i = 0; i < 32; i++) begin
            x = x[31] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return x;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overlen_q, overlen_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic               m_ok_q, m_ok_d;
    logic [CNT_W-1:0]   m_len_q, m_len_d;
    logic               m_overlen_q, m_overlen_d;

    logic               accept;
    logic               handshake;
    logic [31:0]        crc_next;

    assign accept    = s_valid & s_ready_q;
    assign handshake = (state_q == StResult) & m_valid_q & m_ready;
    assign crc_next  = crc_step(lfsr_q, s_data);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        overlen_d   = overlen_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_ok_d      = m_ok_q;
        m_len_d     = m_len_q;
        m_overlen_d = m_overlen_q;

        unique case (state_q)
            StIdle: begin
                // Also raises s_ready in the first cycle out of reset.
                s_ready_d = 1'b1;
                if (accept && !s_last) begin
                    lfsr_d  = crc_next;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (accept && !s_last) begin
                    lfsr_d = crc_next;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // This word is the (MAX_WORDS+1)th payload word.
                    if (cnt_q == MAX_CNT) begin
                        overlen_d = 1'b1;
                    end
                end
            end
            StResult: begin
                s_ready_d = 1'b0;
                if (handshake) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                s_ready_d = 1'b0;
            end
        endcase

        // Trailer: accept can only be true in IDLE or ACC since s_ready is low in RESULT.
        // The trailer itself never adds to the length, so overlen_q is already final.
        if (accept && s_last) begin
            m_ok_d      = (s_data == lfsr_q) & ~overlen_q;
            m_len_d     = cnt_q;
            m_overlen_d = overlen_q;
            m_valid_d   = 1'b1;
            lfsr_d      = CRC_INIT;
            cnt_d       = '0;
            overlen_d   = 1'b0;
            s_ready_d   = 1'b0;
            state_d     = StResult;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= CRC_INIT;
            cnt_q       <= '0;
            overlen_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_ok_q      <= 1'b0;
            m_len_q     <= '0;
            m_overlen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            overlen_q   <= overlen_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_ok_q      <= m_ok_d;
            m_len_q     <= m_len_d;
            m_overlen_q <= m_overlen_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_ok      = m_ok_q;
    assign m_len     = m_len_q;
    assign m_overlen = m_overlen_q;
    assign busy      = (state_q == StAcc);

`ifdef CRC32_FRAME_CHECK_STATS_EN
    logic [31:0] stat_ok_q, stat_ok_d;
    logic [31:0] stat_err_q, stat_err_d;

    always_comb begin
        stat_ok_d  = stat_ok_q;
        stat_err_d = stat_err_q;
        if (stat_clr) begin
            // Clear takes priority over a coincident handshake.
            stat_ok_d  = '0;
            stat_err_d = '0;
        end else if (handshake) begin
            if (m_ok_q) begin
                if (stat_ok_q != 32'hFFFFFFFF) begin
                    stat_ok_d = stat_ok_q + 32'd1;
                end
            end else begin
                if (stat_err_q != 32'hFFFFFFFF) begin
                    stat_err_d = stat_err_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ok_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_ok_q  <= stat_ok_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_err = stat_err_q;
`endif

endmodule
